// File: rtl/super_i3_bch_outer_types.sv
// Shared I.3 outer BCH(3860,3824) types, sizes and the generator polynomial.
// cGEN_POLY is built at elaboration from the minimal polynomials of alpha, alpha^3, alpha^5.
package super_i3_bch_outer_types;

  localparam int cDEC_NUM = 8;
  localparam int cDAT_W   = 16;
  localparam int cM       = 12;
  localparam int cT       = 3;

  localparam logic [cM:0] cIRRPOL = 13'h1053;  // x^12 + x^6 + x^4 + x + 1

  localparam int cINFO_WORDS  = 239;
  localparam int cFRAME_WORDS = 242;
  localparam int cPAR_W       = 36;

  typedef logic [cDAT_W-1:0]          ram_dat_t;
  typedef logic [cDEC_NUM*cDAT_W-1:0] dat_t;

  typedef enum logic [2:0] {sWAIT, sDATA, sPAR0, sPAR1, sPAR2} enc_state_t;

  function automatic logic [cM-1:0] gf_mul(input logic [cM-1:0] a, input logic [cM-1:0] b);
    logic [cM-1:0] r;
    logic [cM-1:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < cM; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[cM-1] ? ((aa << 1) ^ cIRRPOL[cM-1:0]) : (aa << 1);
    end
    return r;
  endfunction

  // Each minimal polynomial is the product of (x + beta^(2^k)) over its cyclotomic coset.
  function automatic logic [cPAR_W:0] gen_poly();
    logic [cM:0][cM-1:0] c;
    logic [cM-1:0]       beta;
    logic [cM:0]         mp;
    logic [cPAR_W:0]     g;
    logic [cPAR_W:0]     acc;
    g = {{cPAR_W{1'b0}}, 1'b1};
    for (int j = 0; j < cT; j++) begin
      beta = {{(cM-1){1'b0}}, 1'b1};
      for (int e = 0; e < 2*j+1; e++) beta = gf_mul(beta, 12'd2);
      c    = '0;
      c[0] = {{(cM-1){1'b0}}, 1'b1};
      for (int k = 0; k < cM; k++) begin
        for (int i = cM; i > 0; i--) c[i] = c[i-1] ^ gf_mul(c[i], beta);
        c[0] = gf_mul(c[0], beta);
        beta = gf_mul(beta, beta);
      end
      for (int i = 0; i <= cM; i++) mp[i] = c[i][0];
      acc = '0;
      for (int i = 0; i <= cM; i++) if (mp[i]) acc = acc ^ (g << i);
      g = acc;
    end
    return g;
  endfunction

  localparam logic [cPAR_W:0] cGEN_POLY = gen_poly();

endpackage

// File: rtl/super_i3_bch_outer_enc_lfsr.sv
// One lane of the BCH outer encoder: 16-bit-parallel remainder update, purely combinational.
// Bit 15 of idat is the highest-degree coefficient; isop restarts from a zero remainder.
module super_i3_bch_outer_enc_lfsr
  import super_i3_bch_outer_types::*;
(
  input  logic              isop,
  input  ram_dat_t          idat,
  input  logic [cPAR_W-1:0] ip,
  output logic [cPAR_W-1:0] op
);

  logic [cPAR_W-1:0] r;
  logic              fb;

  always_comb begin
    r  = isop ? '0 : ip;
    fb = 1'b0;
    for (int b = cDAT_W-1; b >= 0; b--) begin
      fb = r[cPAR_W-1] ^ idat[b];
      r  = {r[cPAR_W-2:0], 1'b0} ^ ({cPAR_W{fb}} & cGEN_POLY[cPAR_W-1:0]);
    end
    op = r;
  end

endmodule

// File: rtl/super_i3_bch_outer_encoder.sv
// I.3 outer BCH(3860,3824) encoder, 8 interleaved lanes: 239 info words in, 242-word frame out.
// Data passes with 1-cycle latency; ordy drops for the three parity cycles, iclkena freezes everything.
module super_i3_bch_outer_encoder
  import super_i3_bch_outer_types::*;
(
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic isop,
  input  logic ival,
  input  dat_t idat,
  output logic ordy,
  output logic osop,
  output logic oeop,
  output logic oval,
  output dat_t odat
);

  localparam logic [7:0] cCNT_LAST = 8'(cINFO_WORDS - 1);

  enc_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [cDEC_NUM-1:0][cPAR_W-1:0] p_q, p_d, p_nxt;
  logic [cDEC_NUM-1:0][cDAT_W-1:0] lane_dat;
  dat_t par0, par1, par2;
  dat_t odat_d;
  logic oval_d, osop_d, oeop_d;
  logic acc;

  // Lanes are bit-interleaved in the frame; parity word 241 is lane-contiguous.
  for (genvar d = 0; d < cDEC_NUM; d++) begin : g_lane
    for (genvar i = 0; i < cDAT_W; i++) begin : g_bit
      assign lane_dat[d][i]       = idat[i*cDEC_NUM + d];
      assign par0[i*cDEC_NUM + d] = p_q[d][20 + i];
      assign par1[i*cDEC_NUM + d] = p_q[d][4 + i];
    end
    assign par2[d*cDAT_W +: cDAT_W] = {6'b0, p_q[d][3:2], 6'b0, p_q[d][1:0]};

    super_i3_bch_outer_enc_lfsr u_lfsr (
      .isop (isop),
      .idat (lane_dat[d]),
      .ip   (p_q[d]),
      .op   (p_nxt[d])
    );
  end

  assign ordy = (state_q == sWAIT) || (state_q == sDATA);
  assign acc  = ival && ordy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    oval_d  = 1'b0;
    osop_d  = 1'b0;
    oeop_d  = 1'b0;
    odat_d  = odat;
    case (state_q)
      sWAIT, sDATA: begin
        if (acc && (isop || state_q == sDATA)) begin
          oval_d  = 1'b1;
          osop_d  = isop;
          odat_d  = idat;
          p_d     = p_nxt;
          state_d = sDATA;
          if (isop) begin
            cnt_d = 8'd1;
          end else if (cnt_q == cCNT_LAST) begin
            cnt_d   = 8'd0;
            state_d = sPAR0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      sPAR0: begin
        oval_d  = 1'b1;
        odat_d  = par0;
        state_d = sPAR1;
      end
      sPAR1: begin
        oval_d  = 1'b1;
        odat_d  = par1;
        state_d = sPAR2;
      end
      sPAR2: begin
        oval_d  = 1'b1;
        oeop_d  = 1'b1;
        odat_d  = par2;
        state_d = sWAIT;
      end
      default: state_d = sWAIT;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= sWAIT;
      cnt_q   <= '0;
      p_q     <= '0;
      oval    <= 1'b0;
      osop    <= 1'b0;
      oeop    <= 1'b0;
      odat    <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      oval    <= oval_d;
      osop    <= osop_d;
      oeop    <= oeop_d;
      odat    <= odat_d;
    end
  end

  a_no_ival_when_busy: assert property (@(posedge iclk) disable iff (ireset) !(iclkena && ival && !ordy));

endmodule
